// File: rtl/clock_pkg.sv
// Shared types and constants for the digital clock blocks.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2,
    ST_CHIME  = 2'd3
  } alarm_state_t;

  typedef logic [7:0] bcd8_t;

  localparam bcd8_t BCD_ZERO = 8'h00;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sec_countdown.sv
// Loadable seconds down-counter; decrements on tick and saturates at 0.
module sec_countdown #(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Asserted when already empty or when this tick consumes the last second,
  // so the owner can leave its state on the tick that expires the period.
  assign zero = (cnt_q == '0) || (tick && (cnt_q == W'(1)));

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm / hourly-chime sequencer: decides when the beeper may sound.
module alarm_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned SNOOZE_SECS = 300,
  parameter int unsigned MAX_SNOOZE  = 3,
  parameter int unsigned CHIME_SECS  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic [7:0] cur_hour,
  input  logic [7:0] cur_min,
  input  logic [7:0] cur_sec,
  input  logic [7:0] alm_hour,
  input  logic [7:0] alm_min,
  input  logic       alm_on,
  input  logic       chime_on,
  input  logic       stop_btn,
  input  logic       snooze_btn,
  output logic       alarm_en,
  output logic       ringing,
  output logic       snoozing,
  output logic [1:0] snooze_left
);

  localparam int unsigned CNT_W = $clog2(max3(RING_SECS, SNOOZE_SECS, CHIME_SECS) + 1);

  alarm_state_t   state_q, state_d;
  logic [1:0]     snooze_left_q, snooze_left_d;
  logic           alarm_en_q, alarm_en_d;
  logic           ringing_q, ringing_d;
  logic           snoozing_q, snoozing_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;
  logic             match;
  logic             top_of_hour;
  logic             expire;

  assign match = tick_1hz && (bcd8_t'(cur_hour) == bcd8_t'(alm_hour)) &&
                 (bcd8_t'(cur_min) == bcd8_t'(alm_min)) && (cur_sec == BCD_ZERO);
  assign top_of_hour = tick_1hz && (cur_min == BCD_ZERO) && (cur_sec == BCD_ZERO);
  assign expire = tick_1hz && cnt_zero;

  sec_countdown #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .tick     (tick_1hz),
    .zero     (cnt_zero)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      snooze_left_q <= 2'd0;
      alarm_en_q    <= 1'b0;
      ringing_q     <= 1'b0;
      snoozing_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      snooze_left_q <= snooze_left_d;
      alarm_en_q    <= alarm_en_d;
      ringing_q     <= ringing_d;
      snoozing_q    <= snoozing_d;
    end
  end

  // Next state; branch order encodes the event priority. A transition that
  // reloads the counter also swallows any tick arriving in the same cycle.
  always_comb begin
    state_d       = state_q;
    snooze_left_d = snooze_left_q;
    cnt_load      = 1'b0;
    cnt_val       = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (match && alm_on) begin
          state_d       = ST_RING;
          cnt_load      = 1'b1;
          cnt_val       = CNT_W'(RING_SECS);
          snooze_left_d = 2'(MAX_SNOOZE);
        end else if (top_of_hour && chime_on) begin
          state_d  = ST_CHIME;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(CHIME_SECS);
        end
      end
      ST_RING: begin
        if (!alm_on || stop_btn) begin
          state_d = ST_IDLE;
        end else if (snooze_btn && (snooze_left_q != 2'd0)) begin
          state_d       = ST_SNOOZE;
          cnt_load      = 1'b1;
          cnt_val       = CNT_W'(SNOOZE_SECS);
          snooze_left_d = snooze_left_q - 2'd1;
        end else if (expire) begin
          state_d = ST_IDLE;
        end
      end
      ST_SNOOZE: begin
        if (!alm_on || stop_btn) begin
          state_d = ST_IDLE;
        end else if (expire) begin
          state_d  = ST_RING;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(RING_SECS);
        end
      end
      ST_CHIME: begin
        if (stop_btn) begin
          state_d = ST_IDLE;
        end else if (match && alm_on) begin
          state_d       = ST_RING;
          cnt_load      = 1'b1;
          cnt_val       = CNT_W'(RING_SECS);
          snooze_left_d = 2'(MAX_SNOOZE);
        end else if (expire) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the next state so they land one cycle after the cause.
  always_comb begin
    alarm_en_d = 1'b0;
    ringing_d  = 1'b0;
    snoozing_d = 1'b0;
    unique case (state_d)
      ST_RING: begin
        alarm_en_d = 1'b1;
        ringing_d  = 1'b1;
      end
      ST_CHIME:  alarm_en_d = 1'b1;
      ST_SNOOZE: snoozing_d = 1'b1;
      default: ;
    endcase
  end

  assign alarm_en    = alarm_en_q;
  assign ringing     = ringing_q;
  assign snoozing    = snoozing_q;
  assign snooze_left = snooze_left_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed self-checking bench for alarm_ctrl with default parameters.
module tb_alarm_ctrl;

  logic       clk;
  logic       rst_n;
  logic       tick_1hz;
  logic [7:0] cur_hour, cur_min, cur_sec;
  logic [7:0] alm_hour, alm_min;
  logic       alm_on, chime_on;
  logic       stop_btn, snooze_btn;
  logic       alarm_en, ringing, snoozing;
  logic [1:0] snooze_left;

  int checks;
  int failures;

  alarm_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_1hz    (tick_1hz),
    .cur_hour    (cur_hour),
    .cur_min     (cur_min),
    .cur_sec     (cur_sec),
    .alm_hour    (alm_hour),
    .alm_min     (alm_min),
    .alm_on      (alm_on),
    .chime_on    (chime_on),
    .stop_btn    (stop_btn),
    .snooze_btn  (snooze_btn),
    .alarm_en    (alarm_en),
    .ringing     (ringing),
    .snoozing    (snoozing),
    .snooze_left (snooze_left)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock cycle of stimulus, driven from a falling edge; returns on the
  // next falling edge so outputs can be sampled away from the rising edge.
  task automatic cyc(input logic t, input logic [7:0] h, input logic [7:0] m,
                     input logic [7:0] s, input logic st, input logic sn);
    tick_1hz   = t;
    cur_hour   = h;
    cur_min    = m;
    cur_sec    = s;
    stop_btn   = st;
    snooze_btn = sn;
    @(negedge clk);
    tick_1hz   = 1'b0;
    stop_btn   = 1'b0;
    snooze_btn = 1'b0;
  endtask

  task automatic filler_ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 8'h12, 8'h34, 8'h56, 1'b0, 1'b0);
  endtask

  task automatic idle_cycle();
    cyc(1'b0, 8'h12, 8'h34, 8'h56, 1'b0, 1'b0);
  endtask

  task automatic snooze_press();
    cyc(1'b0, 8'h12, 8'h34, 8'h56, 1'b0, 1'b1);
  endtask

  task automatic stop_press();
    cyc(1'b0, 8'h12, 8'h34, 8'h56, 1'b1, 1'b0);
  endtask

  task automatic alarm_tick();
    cyc(1'b1, 8'h07, 8'h30, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    tick_1hz   = 1'b0;
    cur_hour   = 8'h00;
    cur_min    = 8'h00;
    cur_sec    = 8'h01;
    alm_hour   = 8'h07;
    alm_min    = 8'h30;
    alm_on     = 1'b1;
    chime_on   = 1'b0;
    stop_btn   = 1'b0;
    snooze_btn = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_alarm_en", int'(alarm_en), 0);
    check("rst_ringing", int'(ringing), 0);
    check("rst_snoozing", int'(snoozing), 0);
    check("rst_snooze_left", int'(snooze_left), 0);
    rst_n = 1'b1;
    idle_cycle();

    // Basic ring: 07:29:59 is no match, 07:30:00 starts ringing.
    cyc(1'b1, 8'h07, 8'h29, 8'h59, 1'b0, 1'b0);
    check("pre_match_alarm_en", int'(alarm_en), 0);
    alarm_tick();
    check("ring_alarm_en", int'(alarm_en), 1);
    check("ring_ringing", int'(ringing), 1);
    check("ring_snooze_left", int'(snooze_left), 3);
    filler_ticks(59);
    idle_cycle();
    check("ring_59_alarm_en", int'(alarm_en), 1);
    filler_ticks(1);
    check("ring_60_alarm_en", int'(alarm_en), 0);
    check("ring_60_ringing", int'(ringing), 0);

    // Snooze cycles and the exhausted-snooze case.
    alarm_tick();
    check("ring2_ringing", int'(ringing), 1);
    for (int k = 0; k < 3; k++) begin
      snooze_press();
      check($sformatf("snz%0d_snoozing", k), int'(snoozing), 1);
      check($sformatf("snz%0d_alarm_en", k), int'(alarm_en), 0);
      check($sformatf("snz%0d_left", k), int'(snooze_left), 2 - k);
      filler_ticks(299);
      check($sformatf("snz%0d_299_snoozing", k), int'(snoozing), 1);
      filler_ticks(1);
      check($sformatf("snz%0d_rering", k), int'(ringing), 1);
      check($sformatf("snz%0d_rering_en", k), int'(alarm_en), 1);
    end
    snooze_press();
    check("snz_4th_ringing", int'(ringing), 1);
    check("snz_4th_snoozing", int'(snoozing), 0);
    check("snz_4th_left", int'(snooze_left), 0);
    stop_press();
    check("stop_ringing", int'(ringing), 0);
    check("stop_alarm_en", int'(alarm_en), 0);

    // Stop and snooze together: stop wins, snooze count untouched.
    alarm_tick();
    check("ring3_left", int'(snooze_left), 3);
    cyc(1'b0, 8'h12, 8'h34, 8'h56, 1'b1, 1'b1);
    check("stop_snz_ringing", int'(ringing), 0);
    check("stop_snz_snoozing", int'(snoozing), 0);
    check("stop_snz_alarm_en", int'(alarm_en), 0);
    check("stop_snz_left", int'(snooze_left), 3);

    // Hourly chime: two ticks of sound, not a ring.
    chime_on = 1'b1;
    cyc(1'b1, 8'h13, 8'h00, 8'h00, 1'b0, 1'b0);
    check("chime_alarm_en", int'(alarm_en), 1);
    check("chime_ringing", int'(ringing), 0);
    filler_ticks(1);
    check("chime_1_alarm_en", int'(alarm_en), 1);
    filler_ticks(1);
    check("chime_2_alarm_en", int'(alarm_en), 0);

    // Alarm at the top of the hour takes priority over the chime.
    alm_hour = 8'h13;
    alm_min  = 8'h00;
    cyc(1'b1, 8'h13, 8'h00, 8'h00, 1'b0, 1'b0);
    check("alm_vs_chime_ringing", int'(ringing), 1);
    check("alm_vs_chime_left", int'(snooze_left), 3);
    stop_press();
    check("alm_vs_chime_stop", int'(alarm_en), 0);
    chime_on = 1'b0;
    alm_hour = 8'h07;
    alm_min  = 8'h30;

    // Disarm mid-snooze: back to idle and never re-rings.
    alarm_tick();
    snooze_press();
    check("disarm_pre_snoozing", int'(snoozing), 1);
    alm_on = 1'b0;
    idle_cycle();
    check("disarm_snoozing", int'(snoozing), 0);
    alm_on = 1'b1;
    filler_ticks(310);
    check("disarm_no_rering", int'(ringing), 0);
    check("disarm_no_sound", int'(alarm_en), 0);

    // Asynchronous reset while ringing.
    alarm_tick();
    check("prereset_ringing", int'(ringing), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_alarm_en", int'(alarm_en), 0);
    check("async_rst_ringing", int'(ringing), 0);
    check("async_rst_snooze_left", int'(snooze_left), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
